// File: rtl/posit_extraction_unit.sv
// rtl/posit_extraction_unit.sv - posit field decoder (sign, regime k, exponent, mantissa, flags).
// Optional input register stage: define POSIT_EXTRACT_INREG_EN (latency 2 instead of 1).
module posit_extraction_unit #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int RS = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        In,
  output logic                Sign,
  output logic signed [RS:0]  k,
  output logic [ES-1:0]       Exponent,
  output logic [N-1:0]        Mantissa,
  output logic [N-2:0]        InRemain,
  output logic                inf,
  output logic                zero
);

  logic [N-1:0] in_q;

`ifdef POSIT_EXTRACT_INREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= '0;
    end else begin
      in_q <= In;
    end
  end
`else
  assign in_q = In;
`endif

  logic               d_sign;
  logic [N-2:0]       d_rem;
  logic               d_lead;
  logic [N-2:0]       d_run_bits;
  logic [RS-1:0]      d_run_len;
  logic               d_hit;
  logic [RS:0]        d_shamt;
  logic [N-2:0]       d_shifted;
  logic signed [RS:0] d_k;
  logic [ES-1:0]      d_exp;
  logic [N-1:0]       d_mant;
  logic               d_zero;
  logic               d_nar;

  always_comb begin
    d_sign = in_q[N-1];
    // Low N-1 bits of the two's complement depend only on the low N-1 input bits.
    d_rem  = d_sign ? (~in_q[N-2:0] + {{(N-2){1'b0}}, 1'b1}) : in_q[N-2:0];
    d_lead = d_rem[N-2];
    // Inverting a run of ones turns regime detection into a plain leading-zero count.
    d_run_bits = d_lead ? ~d_rem : d_rem;

    d_run_len = RS'(N - 1);
    d_hit     = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!d_hit && d_run_bits[i]) begin
        d_run_len = RS'(N - 2 - i);
        d_hit     = 1'b1;
      end
    end

    // Shifting past the terminator leaves exponent then fraction MSB-aligned.
    d_shamt   = {1'b0, d_run_len} + {{RS{1'b0}}, 1'b1};
    d_shifted = d_rem << d_shamt;
    d_exp     = d_shifted[N-2 -: ES];
    d_mant    = {1'b1, d_shifted[N-2-ES:0], {ES{1'b0}}};

    if (d_lead) begin
      d_k = $signed({1'b0, d_run_len}) - $signed({{RS{1'b0}}, 1'b1});
    end else begin
      d_k = -$signed({1'b0, d_run_len});
    end

    d_zero = (in_q == '0);
    d_nar  = (in_q == {1'b1, {(N-1){1'b0}}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sign     <= 1'b0;
      k        <= '0;
      Exponent <= '0;
      Mantissa <= '0;
      InRemain <= '0;
      inf      <= 1'b0;
      zero     <= 1'b0;
    end else if (d_zero || d_nar) begin
      Sign     <= d_nar;
      k        <= '0;
      Exponent <= '0;
      Mantissa <= '0;
      InRemain <= '0;
      inf      <= d_nar;
      zero     <= d_zero;
    end else begin
      Sign     <= d_sign;
      k        <= d_k;
      Exponent <= d_exp;
      Mantissa <= d_mant;
      InRemain <= d_rem;
      inf      <= 1'b0;
      zero     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_posit_extraction_unit.sv
// tb/tb_posit_extraction_unit.sv - directed self-checking bench for posit_extraction_unit.
module tb_posit_extraction_unit;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = 5;
`ifdef POSIT_EXTRACT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk;
  logic               rst;
  logic [N-1:0]       In;
  logic               Sign;
  logic signed [RS:0] k;
  logic [ES-1:0]      Exponent;
  logic [N-1:0]       Mantissa;
  logic [N-2:0]       InRemain;
  logic               inf;
  logic               zero;

  int checks = 0;
  int errors = 0;

  logic [73:0] got;
  assign got = {Sign, k, Exponent, Mantissa, InRemain, inf, zero};

  posit_extraction_unit #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk(clk), .rst(rst), .In(In), .Sign(Sign), .k(k), .Exponent(Exponent),
    .Mantissa(Mantissa), .InRemain(InRemain), .inf(inf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [73:0] pk(input logic s, input int kv, input logic [1:0] e,
                                     input logic [31:0] m, input logic [30:0] r,
                                     input logic i, input logic z);
    return {s, 6'(kv), e, m, r, i, z};
  endfunction

  task automatic step(input logic [N-1:0] v);
    In = v;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    In  = 32'h55555555;
    #1;
    checks++;
    if (got !== 74'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", got, 74'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== 74'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", got, 74'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] vin [4];
    logic [73:0] vexp [4];
    vin[0] = 32'h55555555; vexp[0] = pk(0, 0, 2'b10, 32'hD5555550, 31'h55555555, 0, 0);
    vin[1] = 32'h775555FF; vexp[1] = pk(0, 2, 2'b11, 32'hD5557FC0, 31'h775555FF, 0, 0);
    vin[2] = 32'hFFFFFFFF; vexp[2] = pk(1, -30, 2'b00, 32'h80000000, 31'h00000001, 0, 0);
    vin[3] = 32'hAAAAAAAB; vexp[3] = pk(1, 0, 2'b10, 32'hD5555550, 31'h55555555, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(vin[i]);
      checks++;
      if (got !== vexp[i]) begin
        errors++;
        $display("FAIL basic[%0d] in=%h: got %h expected %h", i, vin[i], got, vexp[i]);
      end
    end
  endtask

  task automatic test_special;
    step(32'h00000000);
    checks++;
    if (got !== pk(0, 0, 0, 0, 0, 0, 1)) begin
      errors++;
      $display("FAIL zero: got %h expected %h", got, pk(0, 0, 0, 0, 0, 0, 1));
    end
    step(32'h80000000);
    checks++;
    if (got !== pk(1, 0, 0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL nar: got %h expected %h", got, pk(1, 0, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_regime_extremes;
    logic [31:0] vin [4];
    logic [73:0] vexp [4];
    vin[0] = 32'h7FFFFFFF; vexp[0] = pk(0, 30, 2'b00, 32'h80000000, 31'h7FFFFFFF, 0, 0);
    vin[1] = 32'h40000000; vexp[1] = pk(0, 0, 2'b00, 32'h80000000, 31'h40000000, 0, 0);
    vin[2] = 32'h00000001; vexp[2] = pk(0, -30, 2'b00, 32'h80000000, 31'h00000001, 0, 0);
    vin[3] = 32'h80000001; vexp[3] = pk(1, 30, 2'b00, 32'h80000000, 31'h7FFFFFFF, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(vin[i]);
      checks++;
      if (got !== vexp[i]) begin
        errors++;
        $display("FAIL regime[%0d] in=%h: got %h expected %h", i, vin[i], got, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [4];
    logic [73:0] vexp [4];
    vin[0] = 32'h775555FF; vexp[0] = pk(0, 2, 2'b11, 32'hD5557FC0, 31'h775555FF, 0, 0);
    vin[1] = 32'h00000000; vexp[1] = pk(0, 0, 0, 0, 0, 0, 1);
    vin[2] = 32'h55555555; vexp[2] = pk(0, 0, 2'b10, 32'hD5555550, 31'h55555555, 0, 0);
    vin[3] = 32'h80000000; vexp[3] = pk(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      In = vin[i];
      @(posedge clk);
      #1;
      if (i >= LAT - 1) begin
        checks++;
        if (got !== vexp[i - (LAT - 1)]) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h expected %h", i, got, vexp[i - (LAT - 1)]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [73:0] dec;
    dec = pk(0, 0, 2'b10, 32'hD5555550, 31'h55555555, 0, 0);
    step(32'h55555555);
    checks++;
    if (got !== dec) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", got, dec);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (got !== 74'd0) begin
      errors++;
      $display("FAIL midstream_async: got %h expected %h", got, 74'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 74'd0) begin
      errors++;
      $display("FAIL midstream_held: got %h expected %h", got, 74'd0);
    end
    rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if (got !== dec) begin
      errors++;
      $display("FAIL post_reset: got %h expected %h", got, dec);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_special;
    test_regime_extremes;
    test_back_to_back;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
